// File: rtl/ccc16_meas_seq.sv
// Measurement sequencer for the CCC16 core: arms the core, collects 2^N capture
// events and publishes average/min/max with a per-sample timeout.
module ccc16_meas_seq #(
    parameter int W         = 16,
    parameter int LOG2N_MAX = 7,
    parameter int TO_W      = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            cfg_mode,
    input  logic [2:0]      cfg_log2n,
    input  logic            cfg_discard,
    input  logic [TO_W-1:0] cfg_timeout,
    output logic            ccc_clr,
    output logic            ccc_tmr_en,
    output logic            ccc_cnt_en,
    input  logic            ccc_cap_valid,
    input  logic [W-1:0]    ccc_cap,
    input  logic            ccc_match,
    input  logic [W-1:0]    ccc_cnt,
    output logic            busy,
    output logic            done,
    output logic            timeout_err,
    output logic [W-1:0]    res_avg,
    output logic [W-1:0]    res_min,
    output logic [W-1:0]    res_max,
    output logic [7:0]      res_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_DISCARD = 3'd2;
    localparam logic [2:0] S_COLLECT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int ACC_W = W + LOG2N_MAX;

    logic [2:0]       state, next_state;
    logic             mode_q;
    logic [2:0]       l2n_q;
    logic             discard_q;
    logic [TO_W-1:0]  timeout_q;
    logic [ACC_W-1:0] acc;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_nxt;
    logic             to_flag;
    logic [2:0]       l2n_clamped;
    logic             armed;
    logic             ev;
    logic [W-1:0]     sample;
    logic [7:0]       cnt_inc;
    logic [7:0]       target;
    logic             last;
    logic             expire;

    always_comb begin
        l2n_clamped = (int'(cfg_log2n) > LOG2N_MAX) ? 3'(LOG2N_MAX) : cfg_log2n;
        armed       = (state == S_DISCARD) || (state == S_COLLECT);
        ev          = armed && (mode_q ? ccc_match : ccc_cap_valid);
        sample      = mode_q ? ccc_cnt : ccc_cap;
        cnt_inc     = res_cnt + 8'd1;
        target      = 8'd1 << l2n_q;
        last        = (cnt_inc == target);
        to_nxt      = to_cnt + TO_W'(1);
        // An event in the expiry cycle takes precedence over the timeout.
        expire      = armed && !ev && (timeout_q != '0) && (to_nxt == timeout_q);
        ccc_clr     = (state == S_CLEAR);
        ccc_tmr_en  = armed && !mode_q;
        ccc_cnt_en  = armed && mode_q;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_CLEAR;
            S_CLEAR:   next_state = discard_q ? S_DISCARD : S_COLLECT;
            S_DISCARD: begin
                if (ev)          next_state = S_COLLECT;
                else if (expire) next_state = S_DONE;
            end
            S_COLLECT: begin
                if (ev && last)  next_state = S_DONE;
                else if (expire) next_state = S_DONE;
            end
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (abort) next_state = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mode_q      <= 1'b0;
            l2n_q       <= '0;
            discard_q   <= 1'b0;
            timeout_q   <= '0;
            acc         <= '0;
            to_cnt      <= '0;
            to_flag     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            res_avg     <= '0;
            res_min     <= '0;
            res_max     <= '0;
            res_cnt     <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
            done  <= (state == S_DONE) && !abort;
            // Abort freezes every result register; only the state returns to IDLE.
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            mode_q    <= cfg_mode;
                            l2n_q     <= l2n_clamped;
                            discard_q <= cfg_discard;
                            timeout_q <= cfg_timeout;
                        end
                    end
                    S_CLEAR: begin
                        acc         <= '0;
                        res_cnt     <= '0;
                        to_cnt      <= '0;
                        to_flag     <= 1'b0;
                        res_min     <= '1;
                        res_max     <= '0;
                        timeout_err <= 1'b0;
                    end
                    S_DISCARD: begin
                        if (ev)                     to_cnt <= '0;
                        else if (timeout_q != '0)   to_cnt <= to_nxt;
                        if (expire)                 to_flag <= 1'b1;
                    end
                    S_COLLECT: begin
                        if (ev) begin
                            acc     <= acc + ACC_W'(sample);
                            res_cnt <= cnt_inc;
                            to_cnt  <= '0;
                            if (sample < res_min) res_min <= sample;
                            if (sample > res_max) res_max <= sample;
                        end else if (timeout_q != '0) begin
                            to_cnt <= to_nxt;
                        end
                        if (expire) to_flag <= 1'b1;
                    end
                    S_DONE: begin
                        res_avg     <= to_flag ? '0 : W'(acc >> l2n_q);
                        timeout_err <= to_flag;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccc16_meas_seq.sv
// Bench for ccc16_meas_seq: table of measurement runs checked through a result
// scoreboard, plus directed sequences for coincident timeout, abort and reset.
module tb_ccc16_meas_seq;

    logic        clk = 1'b0;
    logic        rst, start, abort, cfg_mode, cfg_discard;
    logic [2:0]  cfg_log2n;
    logic [23:0] cfg_timeout;
    logic        ccc_clr, ccc_tmr_en, ccc_cnt_en;
    logic        ccc_cap_valid, ccc_match;
    logic [15:0] ccc_cap, ccc_cnt;
    logic        busy, done, timeout_err;
    logic [15:0] res_avg, res_min, res_max;
    logic [7:0]  res_cnt;

    ccc16_meas_seq #(.W(16), .LOG2N_MAX(7), .TO_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_log2n(cfg_log2n), .cfg_discard(cfg_discard),
        .cfg_timeout(cfg_timeout), .ccc_clr(ccc_clr), .ccc_tmr_en(ccc_tmr_en),
        .ccc_cnt_en(ccc_cnt_en), .ccc_cap_valid(ccc_cap_valid), .ccc_cap(ccc_cap),
        .ccc_match(ccc_match), .ccc_cnt(ccc_cnt), .busy(busy), .done(done),
        .timeout_err(timeout_err), .res_avg(res_avg), .res_min(res_min),
        .res_max(res_max), .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [2:0]  log2n;
        logic        discard;
        logic [23:0] timeout;
        int unsigned n;
        int unsigned gap;
        logic [15:0] s [8];
        logic [15:0] avg;
        logic [15:0] mn;
        logic [15:0] mx;
        logic [7:0]  cnt;
        logic        terr;
    } run_vec_t;

    typedef struct {
        logic [15:0] avg;
        logic [15:0] mn;
        logic [15:0] mx;
        logic [7:0]  cnt;
        logic        terr;
        int unsigned lat;
    } exp_t;

    exp_t        sbq [$];
    run_vec_t    tbl [6];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned last_ev_cyc = 0;
    int unsigned done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t x;
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                x = sbq.pop_front();
                chk("res_avg", res_avg, x.avg);
                chk("res_min", res_min, x.mn);
                chk("res_max", res_max, x.mx);
                chk("res_cnt", res_cnt, x.cnt);
                chk("timeout_err", timeout_err, x.terr);
                chk("done_latency", cyc - last_ev_cyc, x.lat);
            end
        end
    end

    task automatic push_exp(input logic [15:0] avg, input logic [15:0] mn, input logic [15:0] mx,
                            input logic [7:0] cnt, input logic terr, input int unsigned lat);
        exp_t x;
        x.avg = avg; x.mn = mn; x.mx = mx; x.cnt = cnt; x.terr = terr; x.lat = lat;
        sbq.push_back(x);
    endtask

    task automatic wait_done(input int unsigned d0, input int unsigned budget, input string name);
        int unsigned n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, (done_cnt != d0), 1);
    endtask

    task automatic begin_run(input logic mode, input logic [2:0] l2n, input logic disc,
                             input logic [23:0] to);
        cfg_mode = mode; cfg_log2n = l2n; cfg_discard = disc; cfg_timeout = to;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_pulse", ccc_clr, 1);
        chk("busy_rise", busy, 1);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, {busy, done, timeout_err, ccc_clr, ccc_tmr_en, ccc_cnt_en}, 0);
        chk({tag, "_res"}, {res_avg, res_min, res_max, res_cnt}, 0);
    endtask

    task automatic run_vec(input run_vec_t v);
        int unsigned d0 = done_cnt;
        push_exp(v.avg, v.mn, v.mx, v.cnt, v.terr, v.terr ? v.timeout + 2 : 2);
        begin_run(v.mode, v.log2n, v.discard, v.timeout);
        for (int unsigned i = 0; i < v.n; i++) begin
            if (i == 0) begin
                chk("tmr_en", ccc_tmr_en, !v.mode);
                chk("cnt_en", ccc_cnt_en, v.mode);
            end
            if (v.mode) begin ccc_match = 1'b1; ccc_cnt = v.s[i]; end
            else        begin ccc_cap_valid = 1'b1; ccc_cap = v.s[i]; end
            last_ev_cyc = cyc;
            tick();
            ccc_match = 1'b0; ccc_cap_valid = 1'b0;
            for (int unsigned g = 0; g < v.gap; g++) begin
                // strobe of the unselected mode carries a value that would corrupt max
                if (v.mode) begin ccc_cap_valid = 1'b1; ccc_cap = 16'hDEAD; end
                else        begin ccc_match = 1'b1; ccc_cnt = 16'hDEAD; end
                tick();
                ccc_match = 1'b0; ccc_cap_valid = 1'b0;
            end
        end
        wait_done(d0, v.timeout + 40, "done_seen");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: actual=expired required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int unsigned d0;
        tbl[0] = '{mode:1'b0, log2n:3'd2, discard:1'b1, timeout:24'd0, n:5, gap:1,
                   s:'{16'd99, 16'd100, 16'd104, 16'd96, 16'd100, 16'd0, 16'd0, 16'd0},
                   avg:16'd100, mn:16'd96, mx:16'd104, cnt:8'd4, terr:1'b0};
        tbl[1] = '{mode:1'b1, log2n:3'd0, discard:1'b0, timeout:24'd0, n:1, gap:0,
                   s:'{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                   avg:16'd5, mn:16'd5, mx:16'd5, cnt:8'd1, terr:1'b0};
        tbl[2] = '{mode:1'b0, log2n:3'd3, discard:1'b0, timeout:24'd1000, n:8, gap:2,
                   s:'{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80},
                   avg:16'd45, mn:16'd10, mx:16'd80, cnt:8'd8, terr:1'b0};
        tbl[3] = '{mode:1'b1, log2n:3'd1, discard:1'b1, timeout:24'd0, n:3, gap:0,
                   s:'{16'd7, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                   avg:16'd32768, mn:16'd1, mx:16'hFFFF, cnt:8'd2, terr:1'b0};
        // gap of 4 idle cycles puts each later event exactly on the 5-cycle expiry
        tbl[4] = '{mode:1'b1, log2n:3'd2, discard:1'b0, timeout:24'd5, n:4, gap:4,
                   s:'{16'd300, 16'd299, 16'd301, 16'd300, 16'd0, 16'd0, 16'd0, 16'd0},
                   avg:16'd300, mn:16'd299, mx:16'd301, cnt:8'd4, terr:1'b0};
        tbl[5] = '{mode:1'b0, log2n:3'd1, discard:1'b0, timeout:24'd50, n:1, gap:0,
                   s:'{16'd200, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                   avg:16'd0, mn:16'd200, mx:16'd200, cnt:8'd1, terr:1'b1};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_mode = 1'b0; cfg_log2n = 3'd0; cfg_discard = 1'b0; cfg_timeout = 24'd0;
        ccc_cap_valid = 1'b0; ccc_cap = 16'd0; ccc_match = 1'b0; ccc_cnt = 16'd0;
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset");
        tick();

        for (int unsigned i = 0; i < 6; i++) begin
            run_vec(tbl[i]);
            repeat (2) tick();
        end

        // cap 200, 49 silent cycles, cap 300 on the expiry cycle -> accepted
        d0 = done_cnt;
        push_exp(16'd250, 16'd200, 16'd300, 8'd2, 1'b0, 2);
        begin_run(1'b0, 3'd1, 1'b0, 24'd50);
        ccc_cap_valid = 1'b1; ccc_cap = 16'd200; tick(); ccc_cap_valid = 1'b0;
        repeat (49) tick();
        chk("no_early_timeout", done_cnt, d0);
        ccc_cap_valid = 1'b1; ccc_cap = 16'd300; last_ev_cyc = cyc; tick(); ccc_cap_valid = 1'b0;
        wait_done(d0, 20, "coincident_done");
        repeat (2) tick();

        // establish res_avg=100, then abort three cycles into COLLECT
        run_vec(tbl[0]);
        repeat (2) tick();
        d0 = done_cnt;
        begin_run(1'b0, 3'd2, 1'b0, 24'd0);
        ccc_cap_valid = 1'b1; ccc_cap = 16'd500; tick(); ccc_cap_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ignored_busy", ccc_clr, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_tmr_en", ccc_tmr_en, 0);
        chk("abort_res_avg", res_avg, 100);
        for (int unsigned i = 0; i < 6; i++) begin
            ccc_cap_valid = 1'b1; ccc_cap = 16'd1; tick(); ccc_cap_valid = 1'b0;
        end
        chk("abort_no_done", done_cnt, d0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_clr", ccc_clr, 0);
        tick();

        // reset in the middle of COLLECT
        begin_run(1'b1, 3'd2, 1'b0, 24'd0);
        ccc_match = 1'b1; ccc_cnt = 16'd77; tick(); ccc_match = 1'b0;
        chk("pre_rst_cnt", res_cnt, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_all_zero("mid_rst");
        tick();

        // 128 back-to-back 0xFFFF samples plus one extra that must be ignored
        d0 = done_cnt;
        push_exp(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd128, 1'b0, 2);
        begin_run(1'b0, 3'd7, 1'b0, 24'd3);
        ccc_cap_valid = 1'b1; ccc_cap = 16'hFFFF;
        for (int unsigned i = 0; i < 129; i++) begin
            if (i == 127) last_ev_cyc = cyc;
            tick();
        end
        ccc_cap_valid = 1'b0;
        wait_done(d0, 20, "full_run_done");
        repeat (4) tick();
        chk("single_done_pulse", done_cnt, d0 + 1);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
